// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, ALUOp codes,
// opcode/funct constants, instruction classes and control bundles.
package mc_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned OP_W    = 6;
   localparam int unsigned FN_W    = 6;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned STATE_W = 3;
   localparam int unsigned ALUOP_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_e;

   // ALU operation codes, shared with the datapath ALU
   typedef enum logic [ALUOP_W-1:0] {
      ALU_ADD   = 3'd0,
      ALU_SUB   = 3'd1,
      ALU_OR    = 3'd2,
      ALU_PASSB = 3'd3
   } aluop_e;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_BGTZ  = 6'b000111;
   localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
   localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

   localparam logic [FN_W-1:0] FN_ADDU = 6'b100001;
   localparam logic [FN_W-1:0] FN_SUBU = 6'b100011;
   localparam logic [FN_W-1:0] FN_JR   = 6'b001000;

   typedef enum logic [3:0] {
      IC_NONE = 4'd0,
      IC_ADDU = 4'd1,
      IC_SUBU = 4'd2,
      IC_JR   = 4'd3,
      IC_ORI  = 4'd4,
      IC_LW   = 4'd5,
      IC_SW   = 4'd6,
      IC_BEQ  = 4'd7,
      IC_BGTZ = 4'd8,
      IC_LUI  = 4'd9,
      IC_JAL  = 4'd10
   } iclass_e;

   typedef struct packed {
      aluop_e aluop;
      logic   alu_src;
      logic   sign_ext;
      logic   lui_ext;
   } alu_ctl_t;

   typedef struct packed {
      logic     pc_write;
      logic     ir_write;
      logic     reg_dst;
      logic     mem_to_reg;
      logic     beq;
      logic     bgtz;
      logic     jal;
      logic     jr;
      logic     gpr_write;
      logic     dm_write;
      logic     done;
      logic     halt;
      alu_ctl_t alu;
   } ctl_t;

   // ALU operand/operation selection for each instruction class
   function automatic alu_ctl_t alu_ctl(input iclass_e ic);
      alu_ctl_t a;
      a = '0;
      case (ic)
         IC_SUBU: a.aluop = ALU_SUB;
         IC_BEQ: begin
            a.aluop    = ALU_SUB;
            a.sign_ext = 1'b1;
         end
         IC_ORI: begin
            a.aluop   = ALU_OR;
            a.alu_src = 1'b1;
         end
         IC_LW, IC_SW: begin
            a.alu_src  = 1'b1;
            a.sign_ext = 1'b1;
         end
         IC_LUI: begin
            a.aluop   = ALU_PASSB;
            a.alu_src = 1'b1;
            a.lui_ext = 1'b1;
         end
         default: ;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct to instruction-class decode.
module mc_decode
   import mc_pkg::*;
(
   input  logic [OP_W-1:0] opcode_i,
   input  logic [FN_W-1:0] funct_i,
   output iclass_e         iclass_o
);

   always_comb begin
      iclass_o = IC_NONE;
      case (opcode_i)
         OP_RTYPE: begin
            case (funct_i)
               FN_ADDU: iclass_o = IC_ADDU;
               FN_SUBU: iclass_o = IC_SUBU;
               FN_JR:   iclass_o = IC_JR;
               default: iclass_o = IC_NONE;
            endcase
         end
         OP_ORI:  iclass_o = IC_ORI;
         OP_LW:   iclass_o = IC_LW;
         OP_SW:   iclass_o = IC_SW;
         OP_BEQ:  iclass_o = IC_BEQ;
         OP_BGTZ: iclass_o = IC_BGTZ;
         OP_LUI:  iclass_o = IC_LUI;
         OP_JAL:  iclass_o = IC_JAL;
         default: iclass_o = IC_NONE;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS subset controller: Moore FSM FETCH/DECODE/EXEC/MEM/WB(/HALT).
// Define MC_ILLEGAL_TRAP_EN to trap unrecognised instructions in HALT until reset.
module mc_controller
   import mc_pkg::*;
#(
   parameter int unsigned MEM_LAT = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [INSTR_W-1:0] Instr,
   output logic               PC_Write,
   output logic               IR_Write,
   output logic               RegDst,
   output logic               AluSrc,
   output logic               MemToReg,
   output logic               beq,
   output logic               bgtz,
   output logic               jal,
   output logic               jr,
   output logic               GPR_Write,
   output logic               DM_Write,
   output logic               LuiExt,
   output logic               SignExt,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic [STATE_W-1:0] state,
   output logic               done,
   output logic               halt
);

   localparam logic [CNT_W-1:0] MEM_LOAD = CNT_W'(MEM_LAT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OP_W-1:0]  opcode_q;
   logic [FN_W-1:0]  funct_q;
   logic             nop_q;
   iclass_e          iclass;
   alu_ctl_t         alu_c;
   ctl_t             ctl_c;
   ctl_t             ctl;

   mc_decode u_decode (
      .opcode_i (opcode_q),
      .funct_i  (funct_q),
      .iclass_o (iclass)
   );

   // State, MEM counter and the instruction fields latched during FETCH
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_FETCH;
         cnt_q    <= '0;
         opcode_q <= '0;
         funct_q  <= '0;
         nop_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (ctl_c.ir_write) begin
            opcode_q <= Instr[INSTR_W-1 -: OP_W];
            funct_q  <= Instr[FN_W-1:0];
            nop_q    <= (Instr == '0);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ctl_c   = '0;
      alu_c   = alu_ctl(iclass);
      case (state_q)
         S_FETCH: begin
            ctl_c.pc_write = 1'b1;
            ctl_c.ir_write = 1'b1;
            state_d        = S_DECODE;
         end
         S_DECODE: begin
            if (nop_q) begin
               ctl_c.done = 1'b1;
               state_d    = S_FETCH;
            end else if (iclass != IC_NONE) begin
               state_d = S_EXEC;
            end else begin
`ifdef MC_ILLEGAL_TRAP_EN
               state_d = S_HALT;
`else
               ctl_c.done = 1'b1;
               state_d    = S_FETCH;
`endif
            end
         end
         S_EXEC: begin
            ctl_c.alu = alu_c;
            case (iclass)
               IC_BEQ: begin
                  ctl_c.beq  = 1'b1;
                  ctl_c.done = 1'b1;
                  state_d    = S_FETCH;
               end
               IC_BGTZ: begin
                  ctl_c.bgtz = 1'b1;
                  ctl_c.done = 1'b1;
                  state_d    = S_FETCH;
               end
               IC_JR: begin
                  ctl_c.jr   = 1'b1;
                  ctl_c.done = 1'b1;
                  state_d    = S_FETCH;
               end
               IC_JAL: begin
                  ctl_c.jal       = 1'b1;
                  ctl_c.gpr_write = 1'b1;
                  ctl_c.done      = 1'b1;
                  state_d         = S_FETCH;
               end
               IC_LW, IC_SW: begin
                  cnt_d   = MEM_LOAD;
                  state_d = S_MEM;
               end
               default: state_d = S_WB;
            endcase
         end
         S_MEM: begin
            // ALU controls held so the memory address stays stable
            ctl_c.alu = alu_c;
            if (cnt_q == '0) begin
               if (iclass == IC_SW) begin
                  ctl_c.dm_write = 1'b1;
                  ctl_c.done     = 1'b1;
                  state_d        = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_WB: begin
            ctl_c.alu        = alu_c;
            ctl_c.gpr_write  = 1'b1;
            ctl_c.done       = 1'b1;
            ctl_c.reg_dst    = (iclass == IC_ADDU) || (iclass == IC_SUBU);
            ctl_c.mem_to_reg = (iclass == IC_LW);
            state_d          = S_FETCH;
         end
         S_HALT: begin
`ifdef MC_ILLEGAL_TRAP_EN
            ctl_c.halt = 1'b1;
            state_d    = S_HALT;
`else
            state_d    = S_FETCH;
`endif
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Reset forces every control low, including the FETCH strobes
   assign ctl = reset ? ctl_c : '0;

   assign PC_Write  = ctl.pc_write;
   assign IR_Write  = ctl.ir_write;
   assign RegDst    = ctl.reg_dst;
   assign AluSrc    = ctl.alu.alu_src;
   assign MemToReg  = ctl.mem_to_reg;
   assign beq       = ctl.beq;
   assign bgtz      = ctl.bgtz;
   assign jal       = ctl.jal;
   assign jr        = ctl.jr;
   assign GPR_Write = ctl.gpr_write;
   assign DM_Write  = ctl.dm_write;
   assign LuiExt    = ctl.alu.lui_ext;
   assign SignExt   = ctl.alu.sign_ext;
   assign ALUOp     = ctl.alu.aluop;
   assign done      = ctl.done;
   assign halt      = ctl.halt;
   assign state     = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expected control vectors are queued
// when an instruction is issued and popped/compared at every falling edge.
module tb_mc_controller;

   localparam int unsigned MEM_LAT = 3;

   // Observed vector layout: {state[20:18], PC_Write..halt[17:6], AluSrc, LuiExt, SignExt, ALUOp[2:0]}
   localparam int B_SEXT = 3;
   localparam int B_LUI  = 4;
   localparam int B_SRC  = 5;
   localparam int B_HALT = 6;
   localparam int B_DONE = 7;
   localparam int B_DMW  = 8;
   localparam int B_GPRW = 9;
   localparam int B_JR   = 10;
   localparam int B_JAL  = 11;
   localparam int B_BGTZ = 12;
   localparam int B_BEQ  = 13;
   localparam int B_M2R  = 14;
   localparam int B_RDST = 15;
   localparam int B_IRW  = 16;
   localparam int B_PCW  = 17;
   localparam logic [20:0] M_ALL = 21'h1FFFFF;
   localparam logic [20:0] M_CTL = 21'h1FFFC0;

   typedef struct packed {
      logic [20:0] val;
      logic [20:0] mask;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [31:0] Instr;
   logic        PC_Write, IR_Write, RegDst, AluSrc, MemToReg;
   logic        beq, bgtz, jal, jr, GPR_Write, DM_Write, LuiExt, SignExt;
   logic [2:0]  ALUOp;
   logic [2:0]  state;
   logic        done, halt;

   exp_t  exp_q[$];
   string tag_q[$];
   int    checks   = 0;
   int    failures = 0;

   mc_controller #(.MEM_LAT(MEM_LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .Instr     (Instr),
      .PC_Write  (PC_Write),
      .IR_Write  (IR_Write),
      .RegDst    (RegDst),
      .AluSrc    (AluSrc),
      .MemToReg  (MemToReg),
      .beq       (beq),
      .bgtz      (bgtz),
      .jal       (jal),
      .jr        (jr),
      .GPR_Write (GPR_Write),
      .DM_Write  (DM_Write),
      .LuiExt    (LuiExt),
      .SignExt   (SignExt),
      .ALUOp     (ALUOp),
      .state     (state),
      .done      (done),
      .halt      (halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic push_rec(input logic [20:0] v, input logic [20:0] m, input string t);
      exp_t e;
      e.val  = v;
      e.mask = m;
      exp_q.push_back(e);
      tag_q.push_back(t);
   endtask

   task automatic check_cycle();
      exp_t        e;
      string       t;
      logic [20:0] obs;
      @(negedge clk);
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      obs = {state, PC_Write, IR_Write, RegDst, MemToReg, beq, bgtz, jal, jr,
             GPR_Write, DM_Write, done, halt, AluSrc, LuiExt, SignExt, ALUOp};
      checks++;
      assert ((obs & e.mask) === (e.val & e.mask)) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h mask=%h", t, obs, e.val, e.mask);
      end
   endtask

   // Builds the expected per-cycle sequence of one instruction from its class
   task automatic push_expected(input logic [31:0] ins, input string name);
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        is_nop, i_addu, i_subu, i_jr, i_ori, i_lw, i_sw, i_beq, i_bgtz, i_lui, i_jal, legal;
      logic [20:0] v;
      logic [20:0] m;
      op     = ins[31:26];
      fn     = ins[5:0];
      is_nop = (ins == 32'h0);
      i_addu = (op == 6'b000000) && (fn == 6'b100001);
      i_subu = (op == 6'b000000) && (fn == 6'b100011);
      i_jr   = (op == 6'b000000) && (fn == 6'b001000);
      i_ori  = (op == 6'b001101);
      i_lw   = (op == 6'b100011);
      i_sw   = (op == 6'b101011);
      i_beq  = (op == 6'b000100);
      i_bgtz = (op == 6'b000111);
      i_lui  = (op == 6'b001111);
      i_jal  = (op == 6'b000011);
      legal  = i_addu | i_subu | i_jr | i_ori | i_lw | i_sw | i_beq | i_bgtz | i_lui | i_jal;

      v = '0; v[B_PCW] = 1'b1; v[B_IRW] = 1'b1;
      push_rec(v, M_CTL, $sformatf("%s fetch", name));

      v = '0; v[20:18] = 3'd1;
      if (is_nop || !legal) begin
`ifdef MC_ILLEGAL_TRAP_EN
         if (!is_nop) begin
            push_rec(v, M_CTL, $sformatf("%s decode", name));
            for (int k = 0; k < 20; k++) begin
               v = '0; v[20:18] = 3'd5; v[B_HALT] = 1'b1;
               push_rec(v, M_CTL, $sformatf("%s halt%0d", name, k));
            end
            return;
         end
`endif
         v[B_DONE] = 1'b1;
         push_rec(v, M_CTL, $sformatf("%s decode", name));
         return;
      end
      push_rec(v, M_CTL, $sformatf("%s decode", name));

      v = '0; v[20:18] = 3'd2; m = M_CTL;
      if (i_addu) begin v[2:0] = 3'd0; m = m | 21'h27; end
      if (i_subu) begin v[2:0] = 3'd1; m = m | 21'h27; end
      if (i_ori)  begin v[2:0] = 3'd2; v[B_SRC] = 1'b1; m = m | 21'h3F; end
      if (i_lw || i_sw) begin v[2:0] = 3'd0; v[B_SRC] = 1'b1; v[B_SEXT] = 1'b1; m = m | 21'h3F; end
      if (i_lui)  begin v[2:0] = 3'd3; v[B_SRC] = 1'b1; v[B_LUI] = 1'b1; m = m | 21'h37; end
      if (i_beq)  begin v[2:0] = 3'd1; v[B_BEQ] = 1'b1; v[B_DONE] = 1'b1; m = m | 21'h27; end
      if (i_bgtz) begin v[B_BGTZ] = 1'b1; v[B_DONE] = 1'b1; end
      if (i_jr)   begin v[B_JR] = 1'b1; v[B_DONE] = 1'b1; end
      if (i_jal)  begin v[B_JAL] = 1'b1; v[B_GPRW] = 1'b1; v[B_DONE] = 1'b1; end
      push_rec(v, m, $sformatf("%s exec", name));
      if (i_beq || i_bgtz || i_jr || i_jal) return;

      if (i_lw || i_sw) begin
         for (int k = 0; k < int'(MEM_LAT); k++) begin
            v = '0; v[20:18] = 3'd3;
            if (i_sw && k == int'(MEM_LAT) - 1) begin v[B_DMW] = 1'b1; v[B_DONE] = 1'b1; end
            push_rec(v, M_CTL, $sformatf("%s mem%0d", name, k));
         end
         if (i_sw) return;
      end

      v = '0; v[20:18] = 3'd4; v[B_GPRW] = 1'b1; v[B_DONE] = 1'b1; m = M_CTL;
      if (i_addu || i_subu) v[B_RDST] = 1'b1;
      if (i_lw) v[B_M2R] = 1'b1;
      if (i_addu) m = m | 21'h7;
      push_rec(v, m, $sformatf("%s wb", name));
   endtask

   // Issues one instruction; Instr is scrambled once the latch edge has passed.
   // abort_after > 0 stops comparing after that many cycles and drops the rest.
   task automatic run_instr(input logic [31:0] ins, input string name, input int abort_after);
      int n;
      Instr = ins;
      push_expected(ins, name);
      n = exp_q.size();
      if (abort_after > 0) n = abort_after;
      for (int i = 0; i < n; i++) begin
         check_cycle();
         if (i >= 1) Instr = $urandom;
      end
      exp_q.delete();
      tag_q.delete();
   endtask

   task automatic pulse_reset(input int cyc, input string t);
      @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < cyc; i++) begin
         push_rec('0, M_ALL, $sformatf("%s%0d", t, i));
         check_cycle();
      end
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   initial begin
      reset = 1'b1;
      Instr = 32'h0;
      #1 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         push_rec('0, M_ALL, $sformatf("reset%0d", i));
         check_cycle();
      end
      @(posedge clk);
      #1 reset = 1'b1;

      run_instr(32'h0000_0000, "nop0", 0);
      run_instr(32'h0000_0000, "nop1", 0);
      run_instr(32'h0022_1821, "addu", 0);
      run_instr(32'h0022_1823, "subu", 0);
      run_instr(32'h3422_0005, "ori", 0);
      run_instr(32'h3C01_1234, "lui", 0);
      run_instr(32'hAC22_0004, "sw", 0);
      run_instr(32'h8C22_0004, "lw", 0);
      run_instr(32'h0C00_0010, "jal", 0);
      run_instr(32'h1022_0003, "beq", 0);
      run_instr(32'h1C20_0002, "bgtz", 0);
      run_instr(32'h03E0_0008, "jr", 0);

      run_instr(32'h8C22_0004, "lw_abort", 4);
      pulse_reset(2, "midmem_reset");
      run_instr(32'h0022_1821, "addu_after_reset", 0);

      run_instr(32'hFC00_0000, "illegal", 0);
`ifdef MC_ILLEGAL_TRAP_EN
      pulse_reset(2, "halt_reset");
`endif
      run_instr(32'hAC22_0004, "sw_final", 0);
      run_instr(32'h0000_0000, "nop_final", 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
